hs32_capture: RTL and testbench

Input-capture unit for the hs32 peripheral block, the receive-side counterpart of the match/PWM timer: it samples an external pin, detects selected edges, and latches a free-running 32-bit prescaled count into a capture register. It raises `int_capture` for the interrupt controller and holds it until software acknowledges. It flags lost events with `overrun`.

---
 rtl/hs32_capture_if.sv | 25 ++
 rtl/hs32_capture.sv | 129 ++++++++++++
 tb/tb_hs32_capture.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hs32_capture_if.sv
// hs32_capture_if: control, pin and result signals of the hs32 input-capture unit.
// master = software/driver side, slave = the capture unit itself.
interface hs32_capture_if;
    logic        enable;
    logic [2:0]  clk_source;
    logic [1:0]  edge_mode;
    logic        filter_en;
    logic        clear;
    logic        ack;
    logic        io;
    logic [31:0] count;
    logic [31:0] capture;
    logic        int_capture;
    logic        overrun;

    modport master (
        output enable, clk_source, edge_mode, filter_en, clear, ack, io,
        input  count, capture, int_capture, overrun
    );

    modport slave (
        input  enable, clk_source, edge_mode, filter_en, clear, ack, io,
        output count, capture, int_capture, overrun
    );
endinterface

// File: rtl/hs32_capture.sv
// hs32_capture: input-capture unit. Prescaled 32-bit free-running counter,
// two-flop pin synchronizer, optional glitch filter, selectable edge detect,
// capture register with pending interrupt level and sticky overrun flag.
// Ports: clk, reset (sync, active-high), bus (hs32_capture_if.slave):
//   in  enable, clk_source[2:0], edge_mode[1:0], filter_en, clear, ack, io
//   out count[31:0], capture[31:0], int_capture, overrun
module hs32_capture #(
    parameter int FILTER_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    hs32_capture_if.slave bus
);

    localparam int FW = $clog2(FILTER_LEN);

    logic [9:0]    div_q, div_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   capture_q, capture_d;
    logic          int_q, int_d;
    logic          ovr_q, ovr_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          lvl_q, lvl_d;
    logic          prev_q, prev_d;
    logic [FW-1:0] flt_q, flt_d;

    logic tick;
    logic rise;
    logic fall;
    logic evt;

    always_comb begin
        tick = 1'b0;
        case (bus.clk_source)
            3'd1:    tick = 1'b1;
            3'd2:    tick = &div_q[2:0];
            3'd3:    tick = &div_q[5:0];
            3'd4:    tick = &div_q[7:0];
            3'd5:    tick = &div_q[9:0];
            default: tick = 1'b0;
        endcase
    end

    always_comb begin
        div_d   = div_q + 10'd1;
        count_d = count_q;
        if (bus.clear) begin
            div_d   = '0;
            count_d = '0;
        end else if (bus.enable && tick) begin
            count_d = count_q + 32'd1;
        end
    end

    // The filter counter only runs while s2 disagrees with the accepted
    // level; the level flips on the cycle the count would hit FILTER_LEN.
    always_comb begin
        s1_d  = bus.io;
        s2_d  = s1_q;
        lvl_d = lvl_q;
        flt_d = '0;
        if (!bus.filter_en) begin
            lvl_d = s2_q;
        end else if (s2_q != lvl_q) begin
            if (flt_q == FW'(FILTER_LEN - 1)) begin
                lvl_d = s2_q;
            end else begin
                flt_d = flt_q + 1'b1;
            end
        end
    end

    // Edges are taken from the registered level against its previous value,
    // so mode changes never fabricate an event.
    always_comb begin
        prev_d = lvl_q;
        rise   = lvl_q & ~prev_q;
        fall   = ~lvl_q & prev_q;
        evt    = bus.enable
                 & ((bus.edge_mode[0] & rise) | (bus.edge_mode[1] & fall));
    end

    always_comb begin
        capture_d = capture_q;
        int_d     = int_q;
        ovr_d     = ovr_q;
        if (evt) begin
            capture_d = count_q;
            int_d     = 1'b1;
            ovr_d     = bus.ack ? 1'b0 : (ovr_q | int_q);
        end else if (bus.ack) begin
            int_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            capture_q <= '0;
            int_q     <= 1'b0;
            ovr_q     <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            lvl_q     <= 1'b0;
            prev_q    <= 1'b0;
            flt_q     <= '0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            capture_q <= capture_d;
            int_q     <= int_d;
            ovr_q     <= ovr_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            lvl_q     <= lvl_d;
            prev_q    <= prev_d;
            flt_q     <= flt_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.capture     = capture_q;
    assign bus.int_capture = int_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_hs32_capture.sv
// tb_hs32_capture: directed-vector bench for hs32_capture.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_hs32_capture;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hs32_capture_if bus ();

    hs32_capture #(.FILTER_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.clk_source = 3'd0;
        bus.edge_mode  = 2'b00;
        bus.filter_en  = 1'b0;
        bus.clear      = 1'b0;
        bus.ack        = 1'b0;
        bus.io         = 1'b0;
        step(2);
        check("rst_count", bus.count, 32'd0);
        check("rst_capture", bus.capture, 32'd0);
        check("rst_int", {31'd0, bus.int_capture}, 32'd0);
        check("rst_ovr", {31'd0, bus.overrun}, 32'd0);

        // rising capture, /1
        bus.enable     = 1'b1;
        bus.clk_source = 3'd1;
        bus.edge_mode  = 2'b01;
        step(1);
        reset = 1'b0;
        step(99);
        check("run_count", bus.count, 32'd99);
        bus.io = 1'b1;
        step(3);
        check("lat_early_int", {31'd0, bus.int_capture}, 32'd0);
        step(1);
        check("rise_int", {31'd0, bus.int_capture}, 32'd1);
        check("rise_cap", bus.capture, 32'd102);
        bus.io = 1'b0;
        step(8);
        check("fall_ign_cap", bus.capture, 32'd102);
        check("fall_ign_int", {31'd0, bus.int_capture}, 32'd1);

        // overrun
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        check("ack1_int", {31'd0, bus.int_capture}, 32'd0);
        bus.io = 1'b1;
        step(4);
        check("ovr_first_cap", bus.capture, 32'd115);
        check("ovr_first_flag", {31'd0, bus.overrun}, 32'd0);
        bus.io = 1'b0;
        step(16);
        bus.io = 1'b1;
        step(4);
        check("ovr_second_cap", bus.capture, 32'd135);
        check("ovr_second_flag", {31'd0, bus.overrun}, 32'd1);
        check("ovr_second_int", {31'd0, bus.int_capture}, 32'd1);

        // ack coincident with an event
        bus.io = 1'b0;
        step(4);
        bus.io = 1'b1;
        step(3);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        check("ackevt_cap", bus.capture, 32'd143);
        check("ackevt_int", {31'd0, bus.int_capture}, 32'd1);
        check("ackevt_ovr", {31'd0, bus.overrun}, 32'd0);

        // plain ack
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        check("ack_int", {31'd0, bus.int_capture}, 32'd0);
        check("ack_ovr", {31'd0, bus.overrun}, 32'd0);
        check("ack_keep_cap", bus.capture, 32'd143);

        // filter
        bus.io = 1'b0;
        step(5);
        bus.filter_en = 1'b1;
        bus.edge_mode = 2'b11;
        bus.clear     = 1'b1;
        step(1);
        bus.clear = 1'b0;
        check("clear_count", bus.count, 32'd0);
        bus.io = 1'b1;
        step(3);
        bus.io = 1'b0;
        step(10);
        check("glitch_int", {31'd0, bus.int_capture}, 32'd0);
        bus.io = 1'b1;
        step(6);
        check("frise_early", {31'd0, bus.int_capture}, 32'd0);
        step(1);
        check("frise_int", {31'd0, bus.int_capture}, 32'd1);
        check("frise_cap", bus.capture, 32'd19);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        check("fack_int", {31'd0, bus.int_capture}, 32'd0);
        step(2);
        bus.io = 1'b0;
        step(6);
        check("ffall_early", {31'd0, bus.int_capture}, 32'd0);
        step(1);
        check("ffall_int", {31'd0, bus.int_capture}, 32'd1);
        check("ffall_cap", bus.capture, 32'd29);
        check("ffall_ovr", {31'd0, bus.overrun}, 32'd0);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;

        // wrap
        bus.clk_source = 3'd0;
        force dut.count_d = 32'hFFFF_FFFE;
        step(1);
        release dut.count_d;
        check("preload", bus.count, 32'hFFFF_FFFE);
        bus.clk_source = 3'd1;
        step(1);
        check("wrap_max", bus.count, 32'hFFFF_FFFF);
        step(1);
        check("wrap_zero", bus.count, 32'd0);

        // disabled: frozen count, events dropped
        bus.enable    = 1'b0;
        bus.filter_en = 1'b0;
        bus.edge_mode = 2'b01;
        bus.io        = 1'b1;
        step(6);
        check("dis_int", {31'd0, bus.int_capture}, 32'd0);
        check("dis_count", bus.count, 32'd0);
        check("dis_cap", bus.capture, 32'd29);

        // reset with io high: rising event right after release
        bus.enable     = 1'b1;
        bus.clk_source = 3'd0;
        reset          = 1'b1;
        step(1);
        check("mid_rst_cap", bus.capture, 32'd0);
        check("mid_rst_int", {31'd0, bus.int_capture}, 32'd0);
        reset = 1'b0;
        step(3);
        check("rel_early", {31'd0, bus.int_capture}, 32'd0);
        step(1);
        check("rel_int", {31'd0, bus.int_capture}, 32'd1);
        check("rel_cap", bus.capture, 32'd0);

        // prescale /8
        reset          = 1'b1;
        bus.clk_source = 3'd2;
        bus.io         = 1'b0;
        bus.edge_mode  = 2'b00;
        step(1);
        reset = 1'b0;
        step(80);
        check("div8_count", bus.count, 32'd10);
        bus.clk_source = 3'd0;
        step(20);
        check("stop_count", bus.count, 32'd10);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        check("clr_count", bus.count, 32'd0);
        bus.clk_source = 3'd2;
        step(7);
        check("clr_div_pre", bus.count, 32'd0);
        step(1);
        check("clr_div_tick", bus.count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
